// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter.
package div_arb_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t;

    localparam int DIV_W   = 4;
    localparam int DIV_LAT = 5;
    localparam logic [DIV_W-1:0] DIV0_QUOT = 4'hF;
endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin picker.
// Returns the first asserted request at or after rr_ptr, with wrap-around.
module rr_arb_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  index,
    output logic             any
);
    int             pos_s;
    logic [ID_W-1:0] idx_s;

    // Scan from rr_ptr upward and keep the first hit only.
    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        pos_s = 0;
        idx_s = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos_s = int'(rr_ptr) + k;
            if (pos_s >= N_REQ) begin
                pos_s = pos_s - N_REQ;
            end else begin
                pos_s = pos_s;
            end
            idx_s = ID_W'(pos_s);
            if (!any && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                index        = idx_s;
                any          = 1'b1;
            end else begin
                any = any;
            end
        end
    end
endmodule

// File: rtl/div_arbiter.sv
// Shares one 4-bit divider among N_REQ requesters with round-robin arbitration.
// Optional macro DIV0_BYPASS_EN answers y==0 requests locally without using the divider.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [DIV_W*N_REQ-1:0] req_x,
    input  logic [DIV_W*N_REQ-1:0] req_y,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [DIV_W-1:0]       rsp_quot,
    output logic [DIV_W-1:0]       rsp_rem,
    output logic                   rsp_err,
    output logic                   div_start,
    output logic [DIV_W-1:0]       div_x,
    output logic [DIV_W-1:0]       div_y,
    input  logic                   div_valid,
    input  logic [DIV_W-1:0]       div_quot,
    input  logic [DIV_W-1:0]       div_rem
);
    arb_state_t       state_r;
    logic [ID_W-1:0]  rr_ptr_r;
    logic [ID_W-1:0]  id_r;
    logic [N_REQ-1:0] grant_s;
    logic [ID_W-1:0]  idx_s;
    logic             any_s;
    logic [ID_W-1:0]  next_ptr_s;
    logic [DIV_W-1:0] x_sel_s;
    logic [DIV_W-1:0] y_sel_s;

    rr_arb_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr_r),
        .grant  (grant_s),
        .index  (idx_s),
        .any    (any_s)
    );

    assign x_sel_s    = req_x[DIV_W*int'(idx_s) +: DIV_W];
    assign y_sel_s    = req_y[DIV_W*int'(idx_s) +: DIV_W];
    assign next_ptr_s = (idx_s == ID_W'(N_REQ-1)) ? '0 : idx_s + ID_W'(1);

    // Accept strobe: only in idle, and never while reset is held.
    always_comb begin
        if (rst && (state_r == ARB_IDLE)) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
    end

`ifndef DIV0_BYPASS_EN
    assign rsp_err = 1'b0;
`endif

    // Arbitration FSM with operand, result and pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ARB_IDLE;
            rr_ptr_r  <= '0;
            id_r      <= '0;
            div_start <= 1'b0;
            div_x     <= '0;
            div_y     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_quot  <= '0;
            rsp_rem   <= '0;
`ifdef DIV0_BYPASS_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (any_s) begin
                        rr_ptr_r <= next_ptr_s;
                        id_r     <= idx_s;
                        div_x    <= x_sel_s;
                        div_y    <= y_sel_s;
`ifdef DIV0_BYPASS_EN
                        if (y_sel_s == {DIV_W{1'b0}}) begin
                            state_r   <= ARB_RESP;
                            rsp_valid <= 1'b1;
                            rsp_id    <= idx_s;
                            rsp_quot  <= DIV0_QUOT;
                            rsp_rem   <= x_sel_s;
                            rsp_err   <= 1'b1;
                        end else begin
                            state_r   <= ARB_ISSUE;
                            div_start <= 1'b1;
                        end
`else
                        state_r   <= ARB_ISSUE;
                        div_start <= 1'b1;
`endif
                    end else begin
                        state_r <= ARB_IDLE;
                    end
                end
                ARB_ISSUE: begin
                    div_start <= 1'b0;
                    state_r   <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (div_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= id_r;
                        rsp_quot  <= div_quot;
                        rsp_rem   <= div_rem;
`ifdef DIV0_BYPASS_EN
                        rsp_err   <= 1'b0;
`endif
                        state_r   <= ARB_RESP;
                    end else begin
                        state_r <= ARB_WAIT;
                    end
                end
                ARB_RESP: begin
                    rsp_valid <= 1'b0;
                    state_r   <= ARB_IDLE;
                end
                default: begin
                    div_start <= 1'b0;
                    rsp_valid <= 1'b0;
                    state_r   <= ARB_IDLE;
                end
            endcase
        end
    end
endmodule
